// File: rtl/uart_rx.sv
// uart_rx -- 8N1 asynchronous serial receiver.
//
// Synchronises the raw rx pin, validates the start bit, majority-votes three
// mid-bit samples per bit, shifts eight data bits in LSB-first and checks the
// stop bit. A good frame updates `data` with a one-cycle `valid` strobe; a low
// stop bit gives a one-cycle `frame_err` strobe and the receiver then waits for
// the line to return high before looking for the next start edge.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         raw serial input, idle high, asynchronous to clk
//   data[7:0]  last correctly framed byte
//   valid      one-cycle strobe, data updated this cycle
//   frame_err  one-cycle strobe, stop bit sampled low, byte dropped
//   busy       high whenever the receiver is not idle
module uart_rx #(
   parameter int CNT_BPS = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [12:0] CNT_MAX = 13'(CNT_BPS - 1);
   localparam logic [12:0] HALF    = 13'(CNT_BPS / 2);
   localparam logic [12:0] SMP_A   = HALF - 13'd1;
   localparam logic [12:0] SMP_B   = HALF;
   localparam logic [12:0] SMP_C   = HALF + 13'd1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   // 2-of-3 majority vote of the three mid-bit samples
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic       rx_s1;
   logic       rx_s2;
   logic       rx_d;
   logic [2:0] state_r;
   logic [12:0] cnt_r;
   logic [2:0] idx_r;
   logic [7:0] shreg_r;
   logic [1:0] smp_r;

   logic [2:0] state_nx_s;
   logic [12:0] cnt_nx_s;
   logic [12:0] cnt_inc_s;
   logic [2:0] idx_nx_s;
   logic [7:0] shreg_nx_s;
   logic [7:0] data_nx_s;
   logic       valid_nx_s;
   logic       ferr_nx_s;
   logic       wrap_s;
   logic       decide_s;
   logic       bit_s;
   logic       fall_s;

   assign wrap_s    = (cnt_r == CNT_MAX);
   assign decide_s  = (cnt_r == SMP_C);
   assign cnt_inc_s = wrap_s ? 13'd0 : (cnt_r + 13'd1);
   // Third sample is the live synchronised level in the decision cycle itself.
   assign bit_s     = maj3(smp_r[0], smp_r[1], rx_s2);
   assign fall_s    = rx_d & ~rx_s2;

   // Two-flop synchroniser plus one delay stage for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   // Capture the first two of the three mid-bit samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_r <= 2'b11;
      end else if (cnt_r == SMP_A) begin
         smp_r[0] <= rx_s2;
      end else if (cnt_r == SMP_B) begin
         smp_r[1] <= rx_s2;
      end else begin
         smp_r <= smp_r;
      end
   end

   // Next-state, counter, shift register and strobe decisions
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      idx_nx_s   = idx_r;
      shreg_nx_s = shreg_r;
      data_nx_s  = data;
      valid_nx_s = 1'b0;
      ferr_nx_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_nx_s = 13'd0;
            idx_nx_s = 3'd0;
            if (fall_s) begin
               state_nx_s = ST_START;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_START: begin
            cnt_nx_s = cnt_inc_s;
            if (decide_s && bit_s) begin
               // Start bit high at mid-bit: a glitch, not a frame.
               state_nx_s = ST_IDLE;
               cnt_nx_s   = 13'd0;
            end else if (wrap_s) begin
               state_nx_s = ST_DATA;
               idx_nx_s   = 3'd0;
            end else begin
               state_nx_s = ST_START;
            end
         end
         ST_DATA: begin
            cnt_nx_s = cnt_inc_s;
            if (decide_s) begin
               shreg_nx_s = {bit_s, shreg_r[7:1]};
            end else begin
               shreg_nx_s = shreg_r;
            end
            if (wrap_s) begin
               if (idx_r == 3'd7) begin
                  state_nx_s = ST_STOP;
               end else begin
                  idx_nx_s = idx_r + 3'd1;
               end
            end else begin
               idx_nx_s = idx_r;
            end
         end
         ST_STOP: begin
            cnt_nx_s = cnt_inc_s;
            if (decide_s) begin
               cnt_nx_s = 13'd0;
               if (bit_s) begin
                  // Return to IDLE mid stop bit so a back-to-back start is seen.
                  data_nx_s  = shreg_r;
                  valid_nx_s = 1'b1;
                  state_nx_s = ST_IDLE;
               end else begin
                  ferr_nx_s  = 1'b1;
                  state_nx_s = ST_BREAK;
               end
            end else begin
               state_nx_s = ST_STOP;
            end
         end
         ST_BREAK: begin
            cnt_nx_s = 13'd0;
            if (rx_s2) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_BREAK;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = 13'd0;
            idx_nx_s   = 3'd0;
         end
      endcase
   end

   // Receiver state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 13'd0;
         idx_r     <= 3'd0;
         shreg_r   <= 8'h00;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         cnt_r     <= cnt_nx_s;
         idx_r     <= idx_nx_s;
         shreg_r   <= shreg_nx_s;
         data      <= data_nx_s;
         valid     <= valid_nx_s;
         frame_err <= ferr_nx_s;
         busy      <= (state_nx_s != ST_IDLE);
      end
   end

endmodule
